// File: rtl/axis_loopback_tester.sv
// AXI-Stream loopback self-test: drives incrementing bursts out on tx
// and checks the same sequence coming back on rx.
module axis_loopback_tester #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SEED           = 69,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned NUM_BURSTS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [31:0]           first_err_index,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready
);

  localparam logic [DATA_WIDTH-1:0] SEED_V = SEED[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);
  localparam logic [31:0] BL    = BURST_LEN;
  localparam logic [31:0] NB    = NUM_BURSTS;
  localparam logic [31:0] TOTAL = BURST_LEN * NUM_BURSTS;
  localparam logic [31:0] TO    = TIMEOUT_CYCLES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_AWAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [31:0]           tx_cnt_q, tx_cnt_d;
  logic [31:0]           rx_cnt_q, rx_cnt_d;
  logic [31:0]           rx_tot_q, rx_tot_d;
  logic [31:0]           burst_q, burst_d;
  logic [31:0]           idle_q, idle_d;
  logic [15:0]           err_q, err_d;
  logic [31:0]           first_q, first_d;
  logic                  tmo_q, tmo_d;
  logic                  tx_fire;
  logic                  rx_fire;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    exp_d    = exp_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    rx_tot_d = rx_tot_q;
    burst_d  = burst_q;
    idle_d   = idle_q;
    err_d    = err_q;
    first_d  = first_q;
    tmo_d    = tmo_q;

    busy            = (state_q == S_SEND) || (state_q == S_AWAIT);
    done            = (state_q == S_DONE);
    pass            = done && (err_q == 16'd0) && !tmo_q;
    timeout         = tmo_q;
    error_count     = err_q;
    first_err_index = first_q;
    tx_tvalid       = (state_q == S_SEND);
    tx_tdata        = tx_q;
    rx_tready       = busy && (rx_tot_q < TOTAL);
    tx_fire         = tx_tvalid && tx_tready;
    rx_fire         = rx_tready && rx_tvalid;

    // Idle counter runs through SEND too, so the timeout is measured
    // from the last received beat rather than from entering AWAIT.
    if (rx_fire) begin
      exp_d    = exp_q + ONE;
      rx_cnt_d = rx_cnt_q + 32'd1;
      rx_tot_d = rx_tot_q + 32'd1;
      idle_d   = 32'd0;
      if (rx_tdata != exp_q) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (first_q == 32'hFFFF_FFFF) first_d = rx_tot_q;
      end
    end else if (busy && (idle_q < TO)) begin
      idle_d = idle_q + 32'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SEND;
          tx_d     = SEED_V;
          exp_d    = SEED_V;
          tx_cnt_d = 32'd0;
          rx_cnt_d = 32'd0;
          rx_tot_d = 32'd0;
          burst_d  = 32'd0;
          idle_d   = 32'd0;
          err_d    = 16'd0;
          first_d  = 32'hFFFF_FFFF;
          tmo_d    = 1'b0;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          tx_d     = tx_q + ONE;
          tx_cnt_d = tx_cnt_q + 32'd1;
          if (tx_cnt_q == BL - 32'd1) state_d = S_AWAIT;
        end
      end
      S_AWAIT: begin
        // Early words received during SEND carry over into the next burst.
        if (rx_cnt_d >= BL) begin
          rx_cnt_d = rx_cnt_d - BL;
          if (burst_q == NB - 32'd1) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SEND;
            burst_d  = burst_q + 32'd1;
            tx_cnt_d = 32'd0;
          end
        end else if (idle_d >= TO) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_q     <= SEED_V;
      exp_q    <= SEED_V;
      tx_cnt_q <= 32'd0;
      rx_cnt_q <= 32'd0;
      rx_tot_q <= 32'd0;
      burst_q  <= 32'd0;
      idle_q   <= 32'd0;
      err_q    <= 16'd0;
      first_q  <= 32'hFFFF_FFFF;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      exp_q    <= exp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      rx_tot_q <= rx_tot_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      first_q  <= first_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axis_loopback_tester.sv
// Bench for axis_loopback_tester: FIFO loopback model and a tx
// scoreboard; two instances cover default and small-burst setups.
module tb_axis_loopback_tester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic       tmo_s   [2];
  logic [15:0] errc   [2];
  logic [31:0] fidx   [2];
  logic [7:0] tdata   [2];
  logic       tvalid  [2];
  logic       tready  [2];
  logic [7:0] rdata   [2];
  logic       rvalid  [2];
  logic       rready  [2];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_rx = 0;
  int wr, rd, lim, c1, c2, tx_idx;
  bit tr_mode;
  logic [7:0] mem [64];
  logic [7:0] sbq [$];

  always #5 clk = ~clk;

  axis_loopback_tester u_a (
    .sys_clk(clk), .rst(rst), .start(start_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .timeout(tmo_s[0]), .error_count(errc[0]),
    .first_err_index(fidx[0]),
    .tx_tdata(tdata[0]), .tx_tvalid(tvalid[0]),
    .tx_tready(tready[0]),
    .rx_tdata(rdata[0]), .rx_tvalid(rvalid[0]),
    .rx_tready(rready[0])
  );

  axis_loopback_tester #(
    .DATA_WIDTH(8), .SEED(250), .BURST_LEN(10),
    .NUM_BURSTS(1), .TIMEOUT_CYCLES(64)
  ) u_b (
    .sys_clk(clk), .rst(rst), .start(start_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .timeout(tmo_s[1]), .error_count(errc[1]),
    .first_err_index(fidx[1]),
    .tx_tdata(tdata[1]), .tx_tvalid(tvalid[1]),
    .tx_tready(tready[1]),
    .rx_tdata(rdata[1]), .rx_tvalid(rvalid[1]),
    .rx_tready(rready[1])
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(int d);
    @(negedge clk);
    if (tvalid[d]) begin
      if (sbq.size() == 0) begin
        chk("tx_extra_word", 1, 0);
      end else begin
        chk("tx_data", tdata[d], sbq[0]);
        if (tready[d]) begin
          void'(sbq.pop_front());
          mem[wr % 64] = (tx_idx == c1 || tx_idx == c2) ? 8'h00 : tdata[d];
          wr++;
          tx_idx++;
        end
      end
    end
    if (rvalid[d] && rready[d]) begin
      rd++;
      last_rx = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    #1;
    tready[d] = tr_mode ? ~tready[d] : 1'b1;
    rvalid[d] = (rd < wr) && (rd < lim);
    rdata[d]  = mem[rd % 64];
  endtask

  task automatic model_clear(int d, logic [7:0] seed, int n);
    logic [7:0] v;
    wr = 0;
    rd = 0;
    tx_idx = 0;
    sbq.delete();
    for (int i = 0; i < n; i++) begin
      v = seed + 8'(i);
      sbq.push_back(v);
    end
    rvalid[d] = 1'b0;
    tready[d] = 1'b1;
  endtask

  task automatic run(int d, logic [7:0] seed, int n);
    int k;
    model_clear(d, seed, n);
    start_s[d] = 1'b1;
    step(d);
    start_s[d] = 1'b0;
    chk("busy_after_start", busy_s[d], 1);
    chk("tvalid_latency", tvalid[d], 1);
    chk("done_cleared", done_s[d], 0);
    k = 0;
    while (!done_s[d] && k < 3000) begin
      step(d);
      k++;
    end
    if (!done_s[d]) chk("done_wait_bound", 0, 1);
    chk("tx_all_sent", sbq.size(), 0);
  endtask

  task automatic chk_end(int d, logic p, logic t, int e, logic [31:0] f);
    chk("done", done_s[d], 1);
    chk("busy_end", busy_s[d], 0);
    chk("pass", pass_s[d], p);
    chk("timeout", tmo_s[d], t);
    chk("error_count", errc[d], e);
    chk("first_err_index", fidx[d], f);
    chk("rready_end", rready[d], 0);
    chk("tvalid_end", tvalid[d], 0);
  endtask

  task automatic chk_reset(int d, logic [7:0] seed);
    chk("rst_busy", busy_s[d], 0);
    chk("rst_done", done_s[d], 0);
    chk("rst_pass", pass_s[d], 0);
    chk("rst_timeout", tmo_s[d], 0);
    chk("rst_tvalid", tvalid[d], 0);
    chk("rst_rready", rready[d], 0);
    chk("rst_tdata", tdata[d], seed);
    chk("rst_errc", errc[d], 0);
    chk("rst_fidx", fidx[d], 32'hFFFF_FFFF);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      tready[i]  = 1'b1;
      rvalid[i]  = 1'b0;
      rdata[i]   = 8'h00;
    end
    tr_mode = 1'b0;
    lim = 1000;
    c1 = -1;
    c2 = -1;
    wr = 0;
    rd = 0;
    tx_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0, 8'd69);
    chk_reset(1, 8'd250);
    rst = 1'b0;

    run(0, 8'd69, 32);
    chk("done_latency", cyc - last_rx, 0);
    chk_end(0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);

    tr_mode = 1'b1;
    run(0, 8'd69, 32);
    chk_end(0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);
    tr_mode = 1'b0;

    c1 = 5;
    c2 = 20;
    run(0, 8'd69, 32);
    chk_end(0, 1'b0, 1'b0, 2, 32'd5);
    c1 = -1;
    c2 = -1;

    run(1, 8'd250, 10);
    chk_end(1, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);

    lim = 7;
    run(1, 8'd250, 10);
    chk("rx_delivered", rd, 7);
    chk("timeout_latency", cyc - last_rx, 64);
    chk_end(1, 1'b0, 1'b1, 0, 32'hFFFF_FFFF);
    lim = 1000;

    model_clear(0, 8'd69, 32);
    start_s[0] = 1'b1;
    step(0);
    start_s[0] = 1'b0;
    repeat (5) step(0);
    chk("busy_mid_run", busy_s[0], 1);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    chk_reset(0, 8'd69);
    run(0, 8'd69, 32);
    chk_end(0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
